// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default word-address and data widths
//   port_e                  : requester index (PORT0 = core LSU, PORT1 = DMA/loader)
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 14;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way picker.
//   req0/req1 : requests from port 0 / port 1
//   last      : port granted most recently
//   lock      : port 1 asks for burst priority
//   count     : consecutive port-1 grants so far
//   gnt0/gnt1 : one-hot (or zero) pick
module rr_pick2
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_LOCK = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             req0,
    input  logic             req1,
    input  port_e            last,
    input  logic             lock,
    input  logic [CNT_W-1:0] count,
    output logic             gnt0,
    output logic             gnt1
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    logic lock_hold;

    // Port 1 keeps the memory only while it already owns it and has lock budget left.
    assign lock_hold = lock && (last == PORT1) && (count < MAX_CNT);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (lock_hold || (last == PORT0)) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-cycle data memory between the core LSU (port 0)
// and a DMA/loader engine (port 1), one access per cycle, round-robin with a
// bounded burst lock for port 1.
//   clk, rst                      : clock, async active-high reset
//   pX_req/we/addr/wdata          : request side of port X
//   p1_lock                       : port 1 burst priority request
//   pX_gnt                        : combinational accept
//   pX_rvalid/pX_rdata            : registered read response (1-cycle latency)
//   mem_we/mem_addr/mem_wdata     : memory drive
//   mem_rdata                     : memory combinational read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    port_e             last;
    logic [CNT_W-1:0]  lock_cnt;
    logic              pick0;
    logic              pick1;
    logic              rd_accept;
    logic [DATA_W-1:0] rdata_q;

    rr_pick2 #(
        .MAX_LOCK (MAX_LOCK),
        .CNT_W    (CNT_W)
    ) u_pick (
        .req0  (p0_req),
        .req1  (p1_req),
        .last  (last),
        .lock  (p1_lock),
        .count (lock_cnt),
        .gnt0  (pick0),
        .gnt1  (pick1)
    );

    // Grants are masked during reset so no write can reach the memory.
    assign p0_gnt = pick0 & ~rst;
    assign p1_gnt = pick1 & ~rst;

    assign rd_accept = (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= PORT1;
            lock_cnt  <= '0;
            rdata_q   <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (rd_accept) begin
                rdata_q <= mem_rdata;
            end
            if (p0_gnt) begin
                last     <= PORT0;
                lock_cnt <= '0;
            end else if (p1_gnt) begin
                last <= PORT1;
                if (last == PORT1) begin
                    if (lock_cnt != MAX_CNT) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end else begin
                    lock_cnt <= CNT_W'(1);
                end
            end
        end
    end

    // Single response register shared by both ports; rvalid says who owns it.
    assign p0_rdata = rdata_q;
    assign p1_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a behavioural memory plus a reference model
// (integer arbitration state, associative-array memory image, expected response).
module tb_dmem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int ML = 8;

    logic          clk;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int passed = 0;
    int total  = 0;

    dmem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_LOCK (ML)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_lock   (p1_lock),
        .p0_gnt    (p0_gnt),
        .p1_gnt    (p1_gnt),
        .p0_rvalid (p0_rvalid),
        .p1_rvalid (p1_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_rdata  (p1_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up memory contents, identical for the memory and the model.
    function automatic logic [31:0] init_val(input logic [13:0] a);
        logic [7:0] lo;
        lo = a[7:0] ^ 8'h5A;
        if (a == 14'h0010) return 32'hDEADBEEF;
        return {lo, 2'b10, a, 8'hC3};
    endfunction

    // Behavioural memory: combinational read, write on the clock edge.
    logic [31:0] mem     [16384];
    bit          written [16384];
    assign mem_rdata = written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    // Reference model state.
    int          m_last = 1;
    int          m_cnt  = 0;
    int          m_rv   = -1;
    logic [31:0] m_rdata = '0;
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_read(input logic [13:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    function automatic int model_pick();
        if (rst) return -1;
        if (p0_req && !p1_req) return 0;
        if (p1_req && !p0_req) return 1;
        if (!p0_req && !p1_req) return -1;
        if (p1_lock && m_last == 1 && m_cnt < ML) return 1;
        return (m_last == 1) ? 0 : 1;
    endfunction

    task automatic model_commit(input int w);
        m_rv = -1;
        if (w == 0) begin
            if (p0_we) ref_mem[int'(p0_addr)] = p0_wdata;
            else begin m_rv = 0; m_rdata = ref_read(p0_addr); end
            m_cnt  = 0;
            m_last = 0;
        end else if (w == 1) begin
            if (p1_we) ref_mem[int'(p1_addr)] = p1_wdata;
            else begin m_rv = 1; m_rdata = ref_read(p1_addr); end
            m_cnt  = (m_last == 1) ? ((m_cnt + 1 > ML) ? ML : m_cnt + 1) : 1;
            m_last = 1;
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_cnt  = 0;
        m_rv   = -1;
    endtask

    task automatic drive_idle();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        p1_lock = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1;
        drive_idle();
        p0_req = 1; p0_we = 1; p0_addr = 14'h0040; p0_wdata = 32'hFFFF0000;
        p1_req = 1; p1_we = 1; p1_addr = 14'h0041; p1_wdata = 32'h0000FFFF;
        @(negedge clk);
        total++; if (p0_gnt !== 1'b0) $display("FAIL rst_p0_gnt got=%b exp=0", p0_gnt); else passed++;
        total++; if (p1_gnt !== 1'b0) $display("FAIL rst_p1_gnt got=%b exp=0", p1_gnt); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we); else passed++;
        total++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) $display("FAIL rst_rvalid got=%b%b exp=00", p0_rvalid, p1_rvalid); else passed++;
        total++; if (p0_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", p0_rdata); else passed++;
        @(posedge clk);
        #1 rst = 0;
        drive_idle();
        model_reset();
        @(negedge clk);
        total++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) $display("FAIL post_rst_rvalid got=%b%b exp=00", p0_rvalid, p1_rvalid); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        p0_req = 1; p0_we = 0; p0_addr = 14'h0010;
        @(negedge clk);
        total++; if (p0_gnt !== 1'b1) $display("FAIL sr_p0_gnt got=%b exp=1", p0_gnt); else passed++;
        total++; if (p1_gnt !== 1'b0) $display("FAIL sr_p1_gnt got=%b exp=0", p1_gnt); else passed++;
        total++; if (mem_addr !== 14'h0010 || mem_we !== 1'b0) $display("FAIL sr_mem got=%h/%b exp=0010/0", mem_addr, mem_we); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
        p0_req = 0;
        @(negedge clk);
        total++; if (p0_rvalid !== 1'b1) $display("FAIL sr_p0_rvalid got=%b exp=1", p0_rvalid); else passed++;
        total++; if (p0_rdata !== 32'hDEADBEEF) $display("FAIL sr_p0_rdata got=%h exp=deadbeef", p0_rdata); else passed++;
        total++; if (p1_rvalid !== 1'b0 || p1_gnt !== 1'b0) $display("FAIL sr_p1_quiet got=%b/%b exp=0/0", p1_rvalid, p1_gnt); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
    endtask

    task automatic test_alternate();
        int w;
        int e;
        do_reset();
        p0_req = 1; p0_we = 0; p0_addr = 14'($urandom_range(0, 255));
        p1_req = 1; p1_we = 0; p1_addr = 14'($urandom_range(0, 255));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            w = model_pick();
            e = i % 2;
            total++; if (p0_gnt !== (e == 0) || p1_gnt !== (e == 1)) $display("FAIL alt_gnt[%0d] got=%b%b exp_port=%0d", i, p0_gnt, p1_gnt, e); else passed++;
            total++; if (p0_rvalid !== (m_rv == 0) || p1_rvalid !== (m_rv == 1)) $display("FAIL alt_rvalid[%0d] got=%b%b exp_port=%0d", i, p0_rvalid, p1_rvalid, m_rv); else passed++;
            if (m_rv == 0 || m_rv == 1) begin
                total++; if ((m_rv == 0 ? p0_rdata : p1_rdata) !== m_rdata) $display("FAIL alt_rdata[%0d] got=%h exp=%h", i, (m_rv == 0 ? p0_rdata : p1_rdata), m_rdata); else passed++;
            end
            model_commit(w);
            @(posedge clk); #1;
            if (w == 0) p0_addr = 14'($urandom_range(0, 255));
            if (w == 1) p1_addr = 14'($urandom_range(0, 255));
        end
        drive_idle();
    endtask

    task automatic test_lock();
        int w;
        int e;
        do_reset();
        p1_lock = 1;
        p0_req = 1; p0_we = 1; p0_addr = 14'h0100; p0_wdata = $urandom;
        p1_req = 1; p1_we = 1; p1_addr = 14'h0180; p1_wdata = $urandom;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            w = model_pick();
            e = (i % 9 == 8) ? 0 : 1;
            total++; if (p0_gnt !== (e == 0) || p1_gnt !== (e == 1)) $display("FAIL lock_gnt[%0d] got=%b%b exp_port=%0d", i, p0_gnt, p1_gnt, e); else passed++;
            total++; if (mem_we !== 1'b1 || mem_wdata !== (e == 0 ? p0_wdata : p1_wdata)) $display("FAIL lock_mem[%0d] got=%b/%h exp=1/%h", i, mem_we, mem_wdata, (e == 0 ? p0_wdata : p1_wdata)); else passed++;
            model_commit(w);
            @(posedge clk); #1;
            if (w == 0) begin p0_addr = 14'h0100 + 14'(i); p0_wdata = $urandom; end
            if (w == 1) begin p1_addr = 14'h0180 + 14'(i); p1_wdata = $urandom; end
        end
        drive_idle();
    endtask

    task automatic test_write_then_read();
        p1_req = 1; p1_we = 1; p1_addr = 14'h3FFF; p1_wdata = 32'h12345678;
        @(negedge clk);
        total++; if (p1_gnt !== 1'b1) $display("FAIL wr_p1_gnt got=%b exp=1", p1_gnt); else passed++;
        total++; if (mem_we !== 1'b1 || mem_addr !== 14'h3FFF || mem_wdata !== 32'h12345678) $display("FAIL wr_mem got=%b/%h/%h exp=1/3fff/12345678", mem_we, mem_addr, mem_wdata); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
        drive_idle();
        p0_req = 1; p0_we = 0; p0_addr = 14'h3FFF;
        @(negedge clk);
        total++; if (p0_gnt !== 1'b1) $display("FAIL rd_p0_gnt got=%b exp=1", p0_gnt); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
        p0_req = 0;
        @(negedge clk);
        total++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h12345678) $display("FAIL rd_after_wr got=%b/%h exp=1/12345678", p0_rvalid, p0_rdata); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midread();
        drive_idle();
        p1_req = 1; p1_we = 0; p1_addr = 14'h0020;
        @(negedge clk);
        total++; if (p1_gnt !== 1'b1) $display("FAIL mr_p1_gnt got=%b exp=1", p1_gnt); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
        rst = 1;
        drive_idle();
        p0_req = 1; p0_we = 1; p0_addr = 14'h0030; p0_wdata = 32'hAAAA5555;
        model_reset();
        #1;
        total++; if (p1_rvalid !== 1'b0) $display("FAIL mr_rvalid_async got=%b exp=0", p1_rvalid); else passed++;
        @(negedge clk);
        total++; if (p1_rvalid !== 1'b0 || p0_gnt !== 1'b0 || mem_we !== 1'b0) $display("FAIL mr_in_rst got=%b/%b/%b exp=0/0/0", p1_rvalid, p0_gnt, mem_we); else passed++;
        @(posedge clk); #1;
        rst = 0;
        p0_req = 1; p0_we = 0; p0_addr = 14'h0030;
        p1_req = 1; p1_we = 0; p1_addr = 14'h0031;
        @(negedge clk);
        total++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) $display("FAIL mr_first_conflict got=%b%b exp=10", p0_gnt, p1_gnt); else passed++;
        total++; if (p1_rvalid !== 1'b0) $display("FAIL mr_rvalid_after got=%b exp=0", p1_rvalid); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        total++; if (p0_rvalid !== 1'b1 || p0_rdata !== init_val(14'h0030)) $display("FAIL mr_no_write got=%b/%h exp=1/%h", p0_rvalid, p0_rdata, init_val(14'h0030)); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
    endtask

    task automatic idle_ten(input string tag);
        drive_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (mem_we !== 1'b0 || p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p0_gnt !== 1'b0 || p1_gnt !== 1'b0) $display("FAIL %s[%0d] we/rv/gnt got=%b/%b%b/%b%b exp=0/00/00", tag, i, mem_we, p0_rvalid, p1_rvalid, p0_gnt, p1_gnt); else passed++;
            model_commit(model_pick());
            @(posedge clk); #1;
        end
    endtask

    task automatic test_idle();
        drive_idle();
        p0_req = 1; p0_we = 1; p0_addr = 14'h0200; p0_wdata = 32'h0BADF00D;
        @(negedge clk);
        model_commit(model_pick());
        @(posedge clk); #1;
        idle_ten("idle_a");
        p0_req = 1; p0_we = 1; p0_addr = 14'h0201; p0_wdata = 32'h1;
        p1_req = 1; p1_we = 1; p1_addr = 14'h0202; p1_wdata = 32'h2;
        @(negedge clk);
        total++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) $display("FAIL idle_last_held got=%b%b exp=01", p0_gnt, p1_gnt); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
        drive_idle();
        p1_req = 1; p1_we = 1; p1_lock = 1;
        for (int i = 0; i < 20; i++) begin
            p1_addr = 14'h0210 + 14'(i); p1_wdata = $urandom;
            @(negedge clk);
            model_commit(model_pick());
            @(posedge clk); #1;
        end
        idle_ten("idle_b");
        p1_lock = 1;
        p0_req = 1; p0_we = 1; p0_addr = 14'h0203; p0_wdata = 32'h3;
        p1_req = 1; p1_we = 1; p1_addr = 14'h0204; p1_wdata = 32'h4;
        @(negedge clk);
        total++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) $display("FAIL idle_lock_sat got=%b%b exp=10", p0_gnt, p1_gnt); else passed++;
        model_commit(model_pick());
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic new_p0();
        p0_req = ($urandom % 10) < 6; p0_we = $urandom % 2;
        p0_addr = ($urandom % 8 == 0) ? 14'h3FFF : 14'($urandom % 16); p0_wdata = $urandom;
    endtask

    task automatic new_p1();
        p1_req = ($urandom % 10) < 6; p1_we = $urandom % 2;
        p1_addr = ($urandom % 8 == 0) ? 14'h3FFF : 14'($urandom % 16); p1_wdata = $urandom;
    endtask

    task automatic test_random();
        int          w;
        logic        e_we;
        logic [13:0] e_addr;
        logic [31:0] e_wd;
        new_p0();
        new_p1();
        p1_lock = $urandom % 2;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            w = model_pick();
            e_we = 0; e_addr = '0; e_wd = '0;
            if (w == 0) begin e_we = p0_we; e_addr = p0_addr; e_wd = p0_wdata; end
            if (w == 1) begin e_we = p1_we; e_addr = p1_addr; e_wd = p1_wdata; end
            total++; if (p0_gnt !== (w == 0) || p1_gnt !== (w == 1)) $display("FAIL rnd_gnt[%0d] got=%b%b exp_port=%0d", i, p0_gnt, p1_gnt, w); else passed++;
            total++; if (mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wd) $display("FAIL rnd_mem[%0d] got=%b/%h/%h exp=%b/%h/%h", i, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd); else passed++;
            total++; if (p0_rvalid !== (m_rv == 0) || p1_rvalid !== (m_rv == 1)) $display("FAIL rnd_rvalid[%0d] got=%b%b exp_port=%0d", i, p0_rvalid, p1_rvalid, m_rv); else passed++;
            if (m_rv == 0) begin
                total++; if (p0_rdata !== m_rdata) $display("FAIL rnd_p0_rdata[%0d] got=%h exp=%h", i, p0_rdata, m_rdata); else passed++;
            end
            if (m_rv == 1) begin
                total++; if (p1_rdata !== m_rdata) $display("FAIL rnd_p1_rdata[%0d] got=%h exp=%h", i, p1_rdata, m_rdata); else passed++;
            end
            model_commit(w);
            @(posedge clk); #1;
            // A waiting requester holds its request until granted.
            if (w == 0 || !p0_req) new_p0();
            if (w == 1 || !p1_req) new_p1();
            if ($urandom % 8 == 0) p1_lock = ~p1_lock;
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_lock();
        test_write_then_read();
        test_reset_midread();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-cycle data memory (64 KiB, 16384 × 32-bit words, combinational read, write on clock edge) between the core load/store unit (port 0) and a DMA/loader engine (port 1). It grants one access per cycle with round-robin fairness and a bounded burst lock for port 1. It drives the memory's write-enable, address and write-data lines, and returns registered read data to the winning port.

## Interface
- ADDR_W, 14, word-address width (16384 words)
- DATA_W, 32, data width
- MAX_LOCK, 8, maximum consecutive port-1 grants while port 0 is waiting under lock (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- p0_req / p1_req  in  1  access request
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p1_lock  in  1  port 1 requests burst priority
- p0_gnt / p1_gnt  out  1  request accepted this cycle (combinational)
- p0_rvalid / p1_rvalid  out  1  read data valid, 1-cycle pulse
- p0_rdata / p1_rdata  out  DATA_W  read data, valid with rvalid
- mem_we  out  1  memory write enable (MemRW)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory combinational read data

## Operation
- Transfer: a request is accepted when pX_req and pX_gnt are both high in the same cycle. At most one gnt is high per cycle. A requester holds req/we/addr/wdata stable until it sees gnt.
- Memory drive: mem_addr, mem_we and mem_wdata mux from the granted port. With no grant, mem_we=0, mem_addr=0 and mem_wdata=0.
- Arbitration registers:
  - last: the last granted port, held when no grant occurs.
  - lock_cnt: a 0..MAX_LOCK counter of consecutive port-1 grants.
- Decision:
  - Only one port requesting: that port is granted.
  - Both ports requesting: p1 wins if p1_lock && last==1 && lock_cnt<MAX_LOCK. Otherwise the port ≠ last wins.
- lock_cnt update:
  - p1 granted: lock_cnt becomes (last==1 ? lock_cnt+1 : 1), saturating at MAX_LOCK.
  - p0 granted: lock_cnt becomes 0.
  - No grant: lock_cnt holds.
- Reads: on an accepted read, mem_rdata is captured into a shared rdata register at the clock edge. The matching pX_rvalid pulses in the next cycle, and the rdata bus of the non-owning port is don't-care. A write produces no response.
- Ordering: accesses commit in grant order. A port-1 write granted in cycle N is visible to a port-0 read granted in cycle N+1.

## Timing
- Reset values: gnt=0 (forced during rst), rvalid=0, rdata=0, mem_we=0, last=1 (port 0 wins the first conflict), lock_cnt=0.
- Grant: zero latency, combinational from req in the same cycle.
- Write: commits at the rising edge that ends the grant cycle.
- Read: latency 1. Data and rvalid appear the cycle after acceptance.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed.
- Reset mid-operation:
  - rvalid clears immediately and an in-flight read response is dropped.
  - No write occurs while rst is high.
  - Arbitration state returns to its reset values.

## Structure
- Shared package dmem_arb_pkg holds the PORT0/PORT1 index constants and the default ADDR_W/DATA_W.
- The module is flat. The only sub-module is rr_pick2, a combinational 2-way priority picker taking last, lock and count.
- The response path is a plain register stage inside the top module.

## Test plan
- Reset, then p0 reads address 0x0010 with mem holding 0xDEADBEEF → p0_gnt=1 in the same cycle; p0_rvalid=1 and p0_rdata=0xDEADBEEF in the next cycle; p1 outputs stay at 0.
- Both ports request every cycle with p1_lock=0 → grants alternate p0, p1, p0, p1…; the first grant goes to p0.
- p1_lock=1 with both ports requesting continuously and MAX_LOCK=8 → after p1 first wins, it is granted 8 consecutive cycles, then p0 gets 1 grant, then the pattern repeats.
- p1 writes 0x12345678 to address 0x3FFF in cycle N; p0 reads 0x3FFF in cycle N+1 → p0_rdata=0x12345678, confirming the top address and write-then-read ordering.
- rst is asserted the cycle after an accepted p1 read → p1_rvalid stays 0, and after reset the first conflict is granted to p0.
- No requests for 10 cycles → mem_we=0 throughout and no rvalid; lock_cnt and last hold their values, checked by the grant order of the next conflict.
